single_clk_ram_clr_be: RTL and testbench
========================================

// Module: single_clk_ram_clr_be
// PURPOSE
//  Parametrised single-clock simple dual-port RAM (one write port, one registered read port) for the
//  newton multiplier datapath. Adds per-byte write enables, selectable read-during-write mode, and a
//  synchronous sweep-clear engine that zeroes every word one address per cycle, with a busy/done handshake.
//  The sweep also runs automatically after reset release.
// PARAMETERS
//  DATA_WIDTH    64  word width in bits; must be a multiple of 8
//  ADDR_WIDTH    7   address width; DEPTH = 2**ADDR_WIDTH words
//  RDW_NEW_DATA  0   same-address read during write: 0 = q returns old word, 1 = q returns merged new word
// PORTS
//  clk            in   1             rising-edge clock
//  async_clear_n  in   1             asynchronous active-low reset
//  data           in   DATA_WIDTH    write data
//  write_addr     in   ADDR_WIDTH    write address
//  we             in   1             write request
//  be             in   DATA_WIDTH/8  byte enables; be[i] gates data[8i+7:8i]
//  read_addr      in   ADDR_WIDTH    read address
//  re             in   1             read request
//  clear_req      in   1             start sweep clear (level sampled on clk)
//  q              out  DATA_WIDTH    read data (registered)
//  rd_valid       out  1             q updated by the read accepted on the previous edge
//  busy           out  1             sweep clear in progress
//  clear_done     out  1             one-cycle pulse when the sweep completes
//  wr_err         out  1             one-cycle pulse when a write was dropped
// BEHAVIOUR
//  Reset (async_clear_n=0, any time): q=0, rd_valid=0, busy=1, clear_done=0, wr_err=0,
//   state=CLEAR, sweep ptr=0. Array contents are not reset asynchronously. A reset during a sweep
//   restarts it from address 0.
//  FSM IDLE / CLEAR.
//   IDLE->CLEAR: clear_req=1 sampled at an edge; busy=1 after that edge.
//   CLEAR: each edge writes 0 to mem[ptr] and increments ptr (ADDR_WIDTH bits, no wrap used).
//   CLEAR->IDLE: at the edge that writes address DEPTH-1. After that edge busy=0 and clear_done=1
//    for exactly one cycle.
//  Sweep length: busy is high for exactly DEPTH cycles, whether started by clear_req or by reset.
//  clear_req while busy is ignored; it does not extend or restart the sweep.
//  Write (IDLE, we=1): at the edge, mem[write_addr] byte i <= data byte i where be[i]=1.
//   Bytes with be[i]=0 keep their value. A write with be=0 is a no-op with no error.
//  Write dropped when we=1 and either busy=1 or clear_req=1 is sampled in IDLE (clear wins).
//   The array is unchanged and wr_err=1 for the following cycle.
//  Read (re=1): at edge N, q <= word at read_addr and rd_valid=1 for the cycle after N.
//   Latency is 1 clock. With re=0, q holds its value and rd_valid=0.
//  Read while busy=1: accepted, q <= 0, rd_valid=1. The whole array reads as zero from the first
//   busy cycle.
//  Same-address read and write at the same edge (IDLE):
//   RDW_NEW_DATA=0: q <= pre-write word.
//   RDW_NEW_DATA=1: q <= byte-merged result of the write.
//  Different addresses: the read and the write are fully independent.
//  Array is inferred as block RAM: no per-word reset loops; clearing happens only through the sweep.
// TESTING
//  1 Release reset, hold re=1 at addr 5 -> busy high exactly 128 cycles, q=0 throughout,
//    single clear_done pulse, then busy=0.
//  2 Write 0x0123456789ABCDEF to addr 3 with be=0xFF, then be=0x0F data=0xFFFF... ->
//    read of addr 3 returns 0x01234567FFFFFFFF one cycle after re.
//  3 Same-edge write 0xAA..AA and read of addr 9 holding 0x11..11 -> q=0x11..11 (RDW_NEW_DATA=0),
//    q=0xAA..AA (RDW_NEW_DATA=1).
//  4 Fill addr 0..127, pulse clear_req, issue we during sweep -> wr_err pulse per dropped write;
//    after clear_done all 128 addresses read 0.
//  5 Assert async_clear_n=0 mid-sweep at ptr=60 -> outputs reset immediately; after release the
//    sweep restarts at addr 0 and lasts 128 cycles.
//  6 clear_req and we in the same IDLE cycle -> write dropped, wr_err=1, sweep starts;
//    clear_req held during busy -> only one clear_done pulse.

Source files
------------

// File: rtl/single_clk_ram_clr_be.sv
// single_clk_ram_clr_be: single-clock simple dual-port RAM with byte enables and a sweep-clear engine
//   clk            rising-edge clock
//   async_clear_n  asynchronous active-low reset; restarts the sweep from address 0
//   data           write data
//   write_addr     write address
//   we             write request
//   be             byte enables, be[i] gates data[8i+7:8i]
//   read_addr      read address
//   re             read request
//   clear_req      start a sweep clear (level sampled on clk)
//   q              registered read data, holds when re=0
//   rd_valid       q was updated by the read accepted on the previous edge
//   busy           sweep clear in progress
//   clear_done     one-cycle pulse after the last word is cleared
//   wr_err         one-cycle pulse after a dropped write
module single_clk_ram_clr_be #(
    parameter int DATA_WIDTH   = 64,
    parameter int ADDR_WIDTH   = 7,
    parameter bit RDW_NEW_DATA = 1'b0
) (
    input  logic                    clk,
    input  logic                    async_clear_n,
    input  logic [DATA_WIDTH-1:0]   data,
    input  logic [ADDR_WIDTH-1:0]   write_addr,
    input  logic                    we,
    input  logic [DATA_WIDTH/8-1:0] be,
    input  logic [ADDR_WIDTH-1:0]   read_addr,
    input  logic                    re,
    input  logic                    clear_req,
    output logic [DATA_WIDTH-1:0]   q,
    output logic                    rd_valid,
    output logic                    busy,
    output logic                    clear_done,
    output logic                    wr_err
);
    localparam int NB = DATA_WIDTH / 8;
    localparam int DEPTH = 2 ** ADDR_WIDTH;
    localparam logic [0:0] IDLE  = 1'b0;
    localparam logic [0:0] CLEAR = 1'b1;

    logic [DATA_WIDTH-1:0] mem [DEPTH];
    logic [0:0]            state_q, state_d;
    logic [ADDR_WIDTH-1:0] ptr_q, ptr_d;
    logic [DATA_WIDTH-1:0] q_q, q_d;
    logic                  rd_valid_q, clear_done_q, clear_done_d, wr_err_q, wr_err_d;
    logic                  busy_w, last_w, wr_ok;
    logic [DATA_WIDTH-1:0] old_w, merged_w;

    assign busy_w = state_q == CLEAR;
    assign last_w = busy_w && (&ptr_q);
    // a clear request sampled in IDLE takes priority over a write at the same edge
    assign wr_ok  = !busy_w && we && !clear_req;

    // merged_w is the word the write would produce at read_addr; only meaningful when the addresses match
    always_comb begin
        old_w    = mem[read_addr];
        merged_w = old_w;
        for (int i = 0; i < NB; i++)
            if (be[i]) merged_w[8*i +: 8] = data[8*i +: 8];
    end

    // while sweeping the whole array reads as zero, even words the sweep has not reached yet
    always_comb begin
        state_d      = busy_w ? (last_w ? IDLE : CLEAR) : (clear_req ? CLEAR : IDLE);
        ptr_d        = busy_w ? ptr_q + 1'b1 : '0;
        q_d          = !re ? q_q : busy_w ? '0 :
                       (RDW_NEW_DATA && wr_ok && write_addr == read_addr) ? merged_w : old_w;
        wr_err_d     = we && (busy_w || clear_req);
        clear_done_d = last_w;
    end

    always_ff @(posedge clk or negedge async_clear_n) begin
        if (!async_clear_n) begin
            state_q      <= CLEAR;
            ptr_q        <= '0;
            q_q          <= '0;
            rd_valid_q   <= 1'b0;
            clear_done_q <= 1'b0;
            wr_err_q     <= 1'b0;
        end else begin
            state_q      <= state_d;
            ptr_q        <= ptr_d;
            q_q          <= q_d;
            rd_valid_q   <= re;
            clear_done_q <= clear_done_d;
            wr_err_q     <= wr_err_d;
        end
    end

    // array has no reset so it maps onto block RAM; zeroing happens only through the sweep
    always_ff @(posedge clk) begin
        if (busy_w)
            mem[ptr_q] <= '0;
        else if (wr_ok)
            for (int i = 0; i < NB; i++)
                if (be[i]) mem[write_addr][8*i +: 8] <= data[8*i +: 8];
    end

    assign q          = q_q;
    assign rd_valid   = rd_valid_q;
    assign busy       = busy_w;
    assign clear_done = clear_done_q;
    assign wr_err     = wr_err_q;
endmodule

// File: tb/tb_single_clk_ram_clr_be.sv
// tb_single_clk_ram_clr_be: self-checking bench for single_clk_ram_clr_be in both read-during-write modes
module tb_single_clk_ram_clr_be;
    logic        clk = 1'b0;
    logic        async_clear_n = 1'b1;
    logic [63:0] data = '0;
    logic [6:0]  write_addr = '0;
    logic        we = 1'b0;
    logic [7:0]  be = '0;
    logic [6:0]  read_addr = '0;
    logic        re = 1'b0;
    logic        clear_req = 1'b0;
    logic [63:0] q, q1;
    logic        rd_valid, busy, clear_done, wr_err;
    logic        rd_valid1, busy1, clear_done1, wr_err1;

    int total = 0;
    int bad = 0;

    logic [63:0]  mem_m [128];
    logic         busy_m = 1'b1;
    logic [6:0]   ptr_m = '0;
    logic [63:0]  hq0 = '0, hq1 = '0;
    logic [127:0] sb [$];

    always #5 clk = ~clk;

    single_clk_ram_clr_be #(.RDW_NEW_DATA(1'b0)) dut (
        .clk(clk), .async_clear_n(async_clear_n), .data(data), .write_addr(write_addr), .we(we), .be(be),
        .read_addr(read_addr), .re(re), .clear_req(clear_req), .q(q), .rd_valid(rd_valid), .busy(busy),
        .clear_done(clear_done), .wr_err(wr_err));

    single_clk_ram_clr_be #(.RDW_NEW_DATA(1'b1)) dut1 (
        .clk(clk), .async_clear_n(async_clear_n), .data(data), .write_addr(write_addr), .we(we), .be(be),
        .read_addr(read_addr), .re(re), .clear_req(clear_req), .q(q1), .rd_valid(rd_valid1), .busy(busy1),
        .clear_done(clear_done1), .wr_err(wr_err1));

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h want %h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic logic [63:0] merge(input logic [63:0] o, input logic [63:0] d, input logic [7:0] b);
        logic [63:0] r = o;
        for (int i = 0; i < 8; i++) if (b[i]) r[8*i +: 8] = d[8*i +: 8];
        return r;
    endfunction

    task automatic step(input logic we_v, input logic [7:0] be_v, input logic [63:0] d_v, input logic [6:0] wa_v,
                        input logic re_v, input logic [6:0] ra_v, input logic cr_v);
        logic        e_err, e_done;
        logic [63:0] o, n;
        logic [127:0] e;
        we = we_v; be = be_v; data = d_v; write_addr = wa_v; re = re_v; read_addr = ra_v; clear_req = cr_v;
        e_err  = we_v && (busy_m || cr_v);
        e_done = busy_m && ptr_m == 7'd127;
        if (re_v) begin
            o = busy_m ? 64'd0 : mem_m[ra_v];
            n = (!busy_m && we_v && !cr_v && wa_v == ra_v) ? merge(o, d_v, be_v) : o;
            sb.push_back({o, n});
        end
        if (busy_m) begin
            mem_m[ptr_m] = '0;
            if (ptr_m == 7'd127) busy_m = 1'b0;
            ptr_m++;
        end else if (cr_v) begin
            busy_m = 1'b1;
            ptr_m = '0;
        end else if (we_v) mem_m[wa_v] = merge(mem_m[wa_v], d_v, be_v);
        @(posedge clk);
        #1;
        if (re_v) begin
            e = sb.pop_front();
            hq0 = e[127:64];
            hq1 = e[63:0];
        end
        chk("busy", 64'(busy), 64'(busy_m));
        chk("wr_err", 64'(wr_err), 64'(e_err));
        chk("clear_done", 64'(clear_done), 64'(e_done));
        chk("rd_valid", 64'(rd_valid), 64'(re_v));
        chk("q_old_mode", q, hq0);
        chk("q_new_mode", q1, hq1);
    endtask

    task automatic idle_step();
        step(1'b0, 8'h00, 64'd0, 7'd0, 1'b0, 7'd0, 1'b0);
    endtask

    task automatic do_reset();
        #2 async_clear_n = 1'b0;
        #1;
        chk("rst_q", q, 64'd0);
        chk("rst_q_new_mode", q1, 64'd0);
        chk("rst_rd_valid", 64'(rd_valid), 64'd0);
        chk("rst_busy", 64'(busy), 64'd1);
        chk("rst_clear_done", 64'(clear_done), 64'd0);
        chk("rst_wr_err", 64'(wr_err), 64'd0);
        busy_m = 1'b1; ptr_m = '0; hq0 = '0; hq1 = '0; sb.delete();
        @(posedge clk);
        #3 async_clear_n = 1'b1;
    endtask

    // runs the sweep to completion while reading addr 5 and optionally holding clear_req; checks length and pulses
    task automatic run_sweep(input string name, input logic hold_cr);
        int n = 0, dones = 0;
        for (int i = 0; i < 200 && busy; i++) begin
            n++;
            step(1'b0, 8'h00, 64'd0, 7'd0, 1'b1, 7'd5, hold_cr);
            chk({name, "_q_zero"}, q, 64'd0);
            dones += int'(clear_done);
        end
        idle_step();
        dones += int'(clear_done);
        chk({name, "_busy_cycles"}, 64'(n), 64'd128);
        chk({name, "_done_pulses"}, 64'(dones), 64'd1);
    endtask

    typedef struct {
        logic we; logic [7:0] be; logic [63:0] d; logic [6:0] wa;
        logic re; logic [6:0] ra; logic chk; logic [63:0] q0; logic [63:0] q1;
    } vec_t;
    vec_t tv [12];

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "timeout");
    end

    initial begin
        tv[0]  = '{1, 8'hFF, 64'h0123456789ABCDEF, 7'd3,  0, 7'd0,  0, 64'd0, 64'd0};
        tv[1]  = '{1, 8'h0F, 64'hFFFFFFFFFFFFFFFF, 7'd3,  0, 7'd0,  0, 64'd0, 64'd0};
        tv[2]  = '{0, 8'h00, 64'd0,                7'd0,  1, 7'd3,  1, 64'h01234567FFFFFFFF, 64'h01234567FFFFFFFF};
        tv[3]  = '{1, 8'hFF, 64'h1111111111111111, 7'd9,  0, 7'd0,  0, 64'd0, 64'd0};
        tv[4]  = '{1, 8'hFF, 64'hAAAAAAAAAAAAAAAA, 7'd9,  1, 7'd9,  1, 64'h1111111111111111, 64'hAAAAAAAAAAAAAAAA};
        tv[5]  = '{0, 8'h00, 64'd0,                7'd0,  1, 7'd9,  1, 64'hAAAAAAAAAAAAAAAA, 64'hAAAAAAAAAAAAAAAA};
        tv[6]  = '{1, 8'h00, 64'h5555555555555555, 7'd9,  1, 7'd9,  1, 64'hAAAAAAAAAAAAAAAA, 64'hAAAAAAAAAAAAAAAA};
        tv[7]  = '{0, 8'h00, 64'd0,                7'd0,  1, 7'd9,  1, 64'hAAAAAAAAAAAAAAAA, 64'hAAAAAAAAAAAAAAAA};
        tv[8]  = '{1, 8'h81, 64'hCCCCCCCCCCCCCCCC, 7'd10, 1, 7'd9,  1, 64'hAAAAAAAAAAAAAAAA, 64'hAAAAAAAAAAAAAAAA};
        tv[9]  = '{0, 8'h00, 64'd0,                7'd0,  1, 7'd10, 1, 64'hCC000000000000CC, 64'hCC000000000000CC};
        tv[10] = '{1, 8'h02, 64'h000000000000DD00, 7'd10, 1, 7'd10, 1, 64'hCC000000000000CC, 64'hCC0000000000DDCC};
        tv[11] = '{0, 8'h00, 64'd0,                7'd0,  1, 7'd10, 1, 64'hCC0000000000DDCC, 64'hCC0000000000DDCC};
        for (int i = 0; i < 128; i++) mem_m[i] = '0;

        do_reset();
        re = 1'b1; read_addr = 7'd5;
        run_sweep("reset_sweep", 1'b0);

        for (int i = 0; i < 12; i++) begin
            step(tv[i].we, tv[i].be, tv[i].d, tv[i].wa, tv[i].re, tv[i].ra, 1'b0);
            if (tv[i].chk) begin
                chk($sformatf("vec%0d_q", i), q, tv[i].q0);
                chk($sformatf("vec%0d_q_new_mode", i), q1, tv[i].q1);
            end
        end

        for (int a = 0; a < 128; a++)
            step(1'b1, 8'hFF, (64'(a) * 64'h0101010101010101) ^ 64'hF0F0F0F0F0F0F0F0, 7'(a), a > 0, 7'(a - 1), 1'b0);
        step(1'b0, 8'h00, 64'd0, 7'd0, 1'b1, 7'd127, 1'b1);
        for (int i = 0; i < 200 && busy; i++)
            step(i % 3 != 2, 8'hFF, {$urandom, $urandom}, 7'($urandom_range(0, 127)), i[0], 7'(i), 1'b0);
        chk("sweep_finished", 64'(busy), 64'd0);
        for (int a = 0; a < 128; a++) begin
            step(1'b0, 8'h00, 64'd0, 7'd0, 1'b1, 7'(a), 1'b0);
            chk("cleared_word", q, 64'd0);
        end

        step(1'b0, 8'h00, 64'd0, 7'd0, 1'b0, 7'd0, 1'b1);
        for (int i = 0; i < 60; i++) idle_step();
        chk("ptr_at_60", 64'(ptr_m), 64'd60);
        do_reset();
        run_sweep("mid_reset_sweep", 1'b0);

        step(1'b1, 8'hFF, 64'h7777777777777777, 7'd20, 1'b0, 7'd0, 1'b0);
        step(1'b1, 8'hFF, 64'h9999999999999999, 7'd20, 1'b1, 7'd20, 1'b1);
        chk("clr_wins_wr_err", 64'(wr_err), 64'd1);
        chk("clr_wins_busy", 64'(busy), 64'd1);
        chk("clr_wins_q", q, 64'h7777777777777777);
        run_sweep("held_clear", 1'b1);
        step(1'b0, 8'h00, 64'd0, 7'd0, 1'b1, 7'd20, 1'b0);
        chk("addr20_cleared", q, 64'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
